// File: rtl/eci_cmd_defs.sv
// Shared ECI read-path definitions: reorder sequence entry and cache-line width.
package eci_cmd_defs;

  localparam int ECI_CL_BITS = 1024;

  // One splitter sequence entry: beats-1 of the original burst and its starting channel.
  typedef struct packed {
    logic [7:0] len;
    logic       even_odd;
  } reorder_seq_t;

endpackage

// File: rtl/reorder_rd_reg_slice.sv
// Single-stage valid/ready register slice for {data, last}; 1-cycle latency, full throughput.
// Upstream ready = empty slot or downstream draining this cycle; contents held while stalled.
module reorder_rd_reg_slice #(
  parameter int W = 1024
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/reorder_merger_rd.sv
// Re-interleaves two per-VC R streams into one in-order AXI R stream, 1 cycle accept->valid.
// Non-selected channel is backpressured; optional rlast checker under REORDER_MERGER_CHECK_EN.
module reorder_merger_rd
  import eci_cmd_defs::*;
#(
  parameter int DATA_BITS = ECI_CL_BITS
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      mux_r_valid,
  output logic                      mux_r_ready,
  input  logic [8:0]                mux_r_data,
  input  logic [1:0][DATA_BITS-1:0] axi_in_rdata,
  input  logic [1:0]                axi_in_rlast,
  input  logic [1:0]                axi_in_rvalid,
  output logic [1:0]                axi_in_rready,
  output logic [DATA_BITS-1:0]      axi_out_rdata,
  output logic                      axi_out_rlast,
  output logic                      axi_out_rvalid,
  input  logic                      axi_out_rready,
  output logic                      err_seq
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]   state;
  logic         live;
  logic         cur;
  logic [7:0]   len;
  logic [7:0]   cnt;
  logic         slot_free;
  logic         take;
  logic         last_beat;
  reorder_seq_t seq;

  assign seq       = reorder_seq_t'(mux_r_data);
  assign take      = (state == BURST) & axi_in_rvalid[cur] & slot_free;
  assign last_beat = (cnt == len);

  // live keeps the sequence port closed while in reset and for the first cycle after release.
  assign mux_r_ready   = live & ((state == IDLE) | (take & last_beat));
  assign axi_in_rready = (state == BURST && slot_free) ? (cur ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      live  <= 1'b0;
      cur   <= 1'b0;
      len   <= 8'd0;
      cnt   <= 8'd0;
    end else begin
      live <= 1'b1;
      if (mux_r_valid && mux_r_ready) begin
        state <= BURST;
        len   <= seq.len;
        cur   <= seq.even_odd;
        cnt   <= 8'd0;
      end else if (take) begin
        cur <= ~cur;
        cnt <= cnt + 8'd1;
        if (last_beat) state <= IDLE;
      end
    end
  end

  reorder_rd_reg_slice #(.W(DATA_BITS)) u_out_slice (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (take),
    .in_ready  (slot_free),
    .in_data   (axi_in_rdata[cur]),
    .in_last   (last_beat),
    .out_valid (axi_out_rvalid),
    .out_ready (axi_out_rready),
    .out_data  (axi_out_rdata),
    .out_last  (axi_out_rlast)
  );

`ifdef REORDER_MERGER_CHECK_EN
  // Each channel carries half the burst, so its sub-burst ends on one of the final two beats.
  logic exp_last;
  assign exp_last = (len == 8'd0) | (cnt >= len - 8'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_seq <= 1'b0;
    else if (take && (axi_in_rlast[cur] != exp_last)) err_seq <= 1'b1;
  end
`else
  logic unused_rlast;
  assign unused_rlast = ^axi_in_rlast;
  assign err_seq      = 1'b0;
`endif

endmodule
